// File: rtl/conv1d_stream_p.sv
// Parametrised 1-D valid-mode convolution engine with run-time filter load and P parallel lanes.
// Optional build macro CONV_RELU_EN selects a ReLU output stage instead of a signed result.
module conv1d_stream_p #(
  parameter int unsigned T       = 16,
  parameter int unsigned X_COUNT = 64,
  parameter int unsigned F_COUNT = 33,
  parameter int unsigned P       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_data_in_x,
  input  logic                s_valid_x,
  output logic                s_ready_x,
  input  logic signed [T-1:0] s_data_in_f,
  input  logic                s_valid_f,
  output logic                s_ready_f,
  output logic signed [T-1:0] m_data_out_y,
  output logic                m_valid_y,
  input  logic                m_ready_y
);

  localparam int unsigned OP_COUNT = X_COUNT - F_COUNT + 1;
  localparam int unsigned XW       = (X_COUNT > 1) ? $clog2(X_COUNT) : 1;
  localparam int unsigned XW1      = XW + 1;
  localparam int unsigned FW       = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
  localparam int unsigned LW       = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned CW       = $clog2(F_COUNT + 3);

  localparam logic signed [T-1:0] SMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0] SMIN = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

  function automatic logic signed [T-1:0] sat_mul(input logic signed [T-1:0] a,
                                                  input logic signed [T-1:0] b);
    logic signed [2*T-1:0] p;
    p = (2*T)'(a) * (2*T)'(b);
    if (p[2*T-1:T-1] == {(T+1){p[2*T-1]}}) return p[T-1:0];
    return p[2*T-1] ? SMIN : SMAX;
  endfunction

  function automatic logic signed [T-1:0] sat_add(input logic signed [T-1:0] a,
                                                  input logic signed [T-1:0] b);
    logic signed [T:0] s;
    s = (T+1)'(a) + (T+1)'(b);
    if (s[T] == s[T-1]) return s[T-1:0];
    return s[T] ? SMIN : SMAX;
  endfunction

  state_e state_q, state_d;

  logic signed [T-1:0] x_mem [X_COUNT];
  logic signed [T-1:0] f_mem [F_COUNT];

  logic [XW-1:0] wp_x_q;
  logic [FW-1:0] wp_f_q;
  logic [XW-1:0] base_q;
  logic [LW-1:0] lane_q;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] rx_q;
  logic [FW-1:0] rf_q;

  logic signed [T-1:0] x_rd_q [P];
  logic signed [T-1:0] f_rd_q;
  logic signed [T-1:0] prod_q [P];
  logic signed [T-1:0] acc_q  [P];

  logic [XW-1:0]  rd_addr  [P];
  logic [P-1:0]   lane_act;
  logic [XW1-1:0] base_nxt;
  logic           x_fire, f_fire, y_fire;
  logic           x_last, comp_done, lane_last, more_groups;
  logic signed [T-1:0] y_sel, y_out;

  assign x_fire      = s_valid_x & s_ready_x;
  assign f_fire      = s_valid_f & s_ready_f;
  assign y_fire      = m_valid_y & m_ready_y;
  assign x_last      = (wp_x_q == XW'(X_COUNT - 1));
  assign comp_done   = (cnt_q == CW'(F_COUNT + 2));
  assign base_nxt    = {1'b0, base_q} + XW1'(P);
  assign more_groups = (base_nxt < XW1'(OP_COUNT));
  assign lane_last   = (lane_q == LW'(P - 1)) ||
                       (({1'b0, base_q} + XW1'(lane_q) + XW1'(1)) == XW1'(OP_COUNT));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (x_fire && x_last) state_d = StCompute;
      StCompute: if (comp_done) state_d = StOutput;
      StOutput:  if (y_fire && lane_last) state_d = more_groups ? StCompute : StLoad;
      default:   state_d = StLoad;
    endcase
  end

  // Inactive lanes park on address 0; their accumulators are never presented.
  always_comb begin
    for (int k = 0; k < P; k++) begin
      lane_act[k] = (({1'b0, base_q} + XW1'(k)) < XW1'(OP_COUNT));
      rd_addr[k]  = lane_act[k] ? (base_q + XW'(k) + rx_q) : '0;
    end
  end

  always_comb begin
    s_ready_x = (state_q == StLoad);
    s_ready_f = (state_q == StLoad);
    m_valid_y = (state_q == StOutput);
    y_sel     = acc_q[lane_q];
`ifdef CONV_RELU_EN
    y_out     = y_sel[T-1] ? '0 : y_sel;
`else
    y_out     = y_sel;
`endif
    m_data_out_y = m_valid_y ? y_out : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLoad;
      wp_x_q  <= '0;
      wp_f_q  <= '0;
      base_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      rf_q    <= '0;
      for (int k = 0; k < P; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (x_fire) wp_x_q <= x_last ? '0 : wp_x_q + 1'b1;
      if (f_fire) wp_f_q <= (wp_f_q == FW'(F_COUNT - 1)) ? '0 : wp_f_q + 1'b1;
      if (x_fire && x_last) base_q <= '0;

      // Group timeline: clear, F reads, then multiply and accumulate stages trailing by 1 and 2.
      if (state_q == StCompute) begin
        cnt_q <= comp_done ? '0 : cnt_q + 1'b1;
        if (cnt_q == '0) begin
          rx_q <= '0;
          rf_q <= '0;
          for (int k = 0; k < P; k++) acc_q[k] <= '0;
        end else if (cnt_q <= CW'(F_COUNT)) begin
          rx_q <= rx_q + 1'b1;
          rf_q <= rf_q + 1'b1;
        end
        if (cnt_q >= CW'(3)) begin
          for (int k = 0; k < P; k++) acc_q[k] <= sat_add(acc_q[k], prod_q[k]);
        end
      end

      if (y_fire) begin
        if (lane_last) begin
          lane_q <= '0;
          base_q <= more_groups ? base_nxt[XW-1:0] : '0;
        end else begin
          lane_q <= lane_q + 1'b1;
        end
      end
    end
  end

  // Storage and pipeline data registers carry no reset.
  always_ff @(posedge clk) begin
    if (x_fire) x_mem[wp_x_q] <= s_data_in_x;
    if (f_fire) f_mem[wp_f_q] <= s_data_in_f;
    f_rd_q <= f_mem[rf_q];
    for (int k = 0; k < P; k++) begin
      x_rd_q[k] <= x_mem[rd_addr[k]];
      prod_q[k] <= sat_mul(x_rd_q[k], f_rd_q);
    end
  end

endmodule

// File: tb/tb_conv1d_stream_p.sv
// Self-checking bench for conv1d_stream_p: default build plus a 9/3/4 instance, scoreboarded.
module tb_conv1d_stream_p;

  localparam int T = 16;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  logic signed [T-1:0] d_x, d_f;
  logic d_vx, d_vf, d_ry;

  logic a_vx, a_vf, a_ry, a_rx, a_rf, a_vy;
  logic b_vx, b_vf, b_ry, b_rx, b_rf, b_vy;
  logic signed [T-1:0] a_y, b_y;
  logic o_rx, o_rf, o_vy;
  logic signed [T-1:0] o_y;

  always #5 clk = ~clk;

  assign a_vx = d_vx & ~sel;
  assign a_vf = d_vf & ~sel;
  assign b_vx = d_vx & sel;
  assign b_vf = d_vf & sel;
  assign a_ry = sel ? 1'b1 : d_ry;
  assign b_ry = sel ? d_ry : 1'b1;
  assign o_rx = sel ? b_rx : a_rx;
  assign o_rf = sel ? b_rf : a_rf;
  assign o_vy = sel ? b_vy : a_vy;
  assign o_y  = sel ? b_y : a_y;

  conv1d_stream_p #(.T(16), .X_COUNT(64), .F_COUNT(33), .P(4)) dut_a (
    .clk(clk), .reset(reset),
    .s_data_in_x(d_x), .s_valid_x(a_vx), .s_ready_x(a_rx),
    .s_data_in_f(d_f), .s_valid_f(a_vf), .s_ready_f(a_rf),
    .m_data_out_y(a_y), .m_valid_y(a_vy), .m_ready_y(a_ry)
  );

  conv1d_stream_p #(.T(16), .X_COUNT(9), .F_COUNT(3), .P(4)) dut_b (
    .clk(clk), .reset(reset),
    .s_data_in_x(d_x), .s_valid_x(b_vx), .s_ready_x(b_rx),
    .s_data_in_f(d_f), .s_valid_f(b_vf), .s_ready_f(b_rf),
    .m_data_out_y(b_y), .m_valid_y(b_vy), .m_ready_y(b_ry)
  );

  int nx, nfl, nop, np, fwp;
  logic signed [T-1:0] mx [64];
  logic signed [T-1:0] mf [33];
  logic signed [T-1:0] fs [64];
  logic signed [T-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: saturated products, saturation after every add, optional ReLU on the result.
  task automatic push_expected();
    longint acc;
    for (int i = 0; i < nop; i++) begin
      acc = 0;
      for (int j = 0; j < nfl; j++)
        acc = sat16(acc + sat16(longint'(mx[i+j]) * longint'(mf[j])));
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      exp_q.push_back(T'(acc));
    end
  endtask

  task automatic load(input int nsend_f, input bit wait_out);
    int lat;
    check("load_ready_x", o_rx, 1);
    check("load_ready_f", o_rf, 1);
    for (int i = 0; i < nx; i++) begin
      d_vx = 1'b1;
      d_x  = mx[i];
      if (i < nsend_f) begin
        d_vf = 1'b1;
        d_f  = fs[i];
        mf[fwp] = fs[i];
        fwp = (fwp + 1) % nfl;
      end else begin
        d_vf = 1'b0;
      end
      @(negedge clk);
    end
    d_vx = 1'b0;
    d_vf = 1'b0;
    if (wait_out) begin
      lat = 1;
      while (!o_vy && lat < 400) begin
        @(negedge clk);
        lat++;
      end
      check("latency", lat, nfl + 4);
    end
  endtask

  task automatic collect(input int stall_r, input bit spam);
    int w;
    logic signed [T-1:0] held;
    for (int r = 0; r < nop; r++) begin
      w = 0;
      while (!o_vy && w < 200) begin
        if (spam) begin
          d_vx = 1'b1;
          d_vf = 1'b1;
          d_x  = 16'sh5a5a;
          d_f  = -16'sd7;
        end
        if (w == 1) check("compute_ready_x", o_rx, 0);
        @(negedge clk);
        w++;
      end
      d_vx = 1'b0;
      d_vf = 1'b0;
      if (!o_vy) begin
        check("timeout_valid", o_vy, 1);
        exp_q.delete();
        return;
      end
      if (r % np != 0) check("burst_gap", w, 0);
      else if (r > 0) check("group_gap", w, nfl + 3);
      if (r == stall_r) begin
        d_ry = 1'b0;
        held = o_y;
        repeat (5) begin
          @(negedge clk);
          check("stall_hold", {o_vy, o_y}, {1'b1, held});
        end
        d_ry = 1'b1;
      end
      check("result", o_y, exp_q.pop_front());
      @(negedge clk);
    end
    check("idle_valid", o_vy, 0);
    check("idle_data", o_y, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sel   = 1'b0;
    d_x = '0; d_f = '0; d_vx = 1'b0; d_vf = 1'b0; d_ry = 1'b1;
    nx = 64; nfl = 33; nop = 32; np = 4; fwp = 0;
    repeat (3) @(negedge clk);
    check("rst_ready_x", o_rx, 1);
    check("rst_ready_f", o_rf, 1);
    check("rst_valid", o_vy, 0);
    check("rst_data", o_y, 0);
    reset = 1'b0;
    @(negedge clk);

    // All ones: every result is 33.
    for (int i = 0; i < 64; i++) mx[i] = 16'sd1;
    for (int i = 0; i < 33; i++) fs[i] = 16'sd1;
    load(33, 1'b1);
    push_expected();
    collect(-1, 1'b0);

    // Product saturation.
    for (int i = 0; i < 64; i++) mx[i] = 16'sd32767;
    for (int i = 0; i < 33; i++) fs[i] = 16'sd32767;
    load(33, 1'b1);
    push_expected();
    collect(-1, 1'b0);

    // Negative results (ReLU build clamps to 0).
    for (int i = 0; i < 64; i++) mx[i] = 16'sd1;
    for (int i = 0; i < 33; i++) fs[i] = -16'sd1;
    load(33, 1'b1);
    push_expected();
    collect(-1, 1'b0);

    // Random data, stall on lane 2 of the first group, writes attempted outside LOAD.
    for (int i = 0; i < 64; i++) mx[i] = T'(int'($urandom_range(600)) - 300);
    for (int i = 0; i < 33; i++) fs[i] = T'(int'($urandom_range(600)) - 300);
    load(33, 1'b1);
    push_expected();
    collect(2, 1'b1);

    // Reset mid-COMPUTE, then reload x only; filter stays.
    for (int i = 0; i < 64; i++) mx[i] = T'(int'($urandom_range(600)) - 300);
    for (int i = 0; i < 33; i++) fs[i] = T'(int'($urandom_range(600)) - 300);
    load(33, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_ready_x", o_rx, 1);
    check("async_ready_f", o_rf, 1);
    check("async_valid", o_vy, 0);
    check("async_data", o_y, 0);
    @(negedge clk);
    reset = 1'b0;
    fwp = 0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) mx[i] = T'(int'($urandom_range(600)) - 300);
    load(0, 1'b1);
    push_expected();
    collect(-1, 1'b0);

    // 40 coefficients in one LOAD window: write pointer wraps onto f[0..6].
    for (int i = 0; i < 64; i++) mx[i] = T'(int'($urandom_range(600)) - 300);
    for (int i = 0; i < 40; i++) fs[i] = T'(int'($urandom_range(600)) - 300);
    load(40, 1'b1);
    push_expected();
    collect(-1, 1'b0);

    // Small instance: partial final group.
    sel = 1'b1;
    nx = 9; nfl = 3; nop = 7; np = 4; fwp = 0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) mx[i] = T'(i);
    for (int i = 0; i < 3; i++) fs[i] = 16'sd1;
    load(3, 1'b1);
    push_expected();
    collect(-1, 1'b0);
    check("b_ready_x_after", o_rx, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv1d_stream_p.md
# conv1d_stream_p

Parametrised 1-D valid-mode convolution engine, successor to the fixed 64-tap/33-tap, 4-lane convolver. Width, input length, filter length and lane count are parameters. The filter is loaded at run time over its own stream port rather than held in a hard-wired ROM. A final output group is allowed to be partial. Output data holds stable under backpressure. It sits between an upstream activation stream and a downstream layer in the generated CNN pipeline.

## Interface
- T, 16, sample/coefficient/result width (signed two's complement)
- X_COUNT, 64, input vector length
- F_COUNT, 33, filter length; 1 ≤ F_COUNT ≤ X_COUNT
- P, 4, parallel MAC lanes; 1 ≤ P ≤ OP_COUNT, where OP_COUNT = X_COUNT−F_COUNT+1
- clk  in  1  clock; single clock domain, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- s_data_in_x  in  T  input sample
- s_valid_x  in  1  sample valid
- s_ready_x  out  1  block accepts a sample
- s_data_in_f  in  T  filter coefficient
- s_valid_f  in  1  coefficient valid
- s_ready_f  out  1  block accepts a coefficient
- m_data_out_y  out  T  result
- m_valid_y  out  1  result valid
- m_ready_y  in  1  downstream accepts result

## Operation
- States: LOAD, COMPUTE, OUTPUT.
- **LOAD**
  - s_ready_x=1 and s_ready_f=1.
  - A sample is accepted when s_valid_x&s_ready_x and written to x[wp_x]; wp_x then increments.
  - When the accepted sample is at wp_x=X_COUNT−1, wp_x returns to 0, base is set to 0, and the state goes to COMPUTE.
  - A coefficient is accepted when s_valid_f&s_ready_f and written to f[wp_f]; wp_f wraps F_COUNT−1→0.
  - x and f transfers are independent and may occur in the same cycle.
- **COMPUTE**
  - Both readies are 0.
  - Lane k (0..P−1) computes y[base+k] = Σ_{j=0}^{F_COUNT−1} x[base+k+j]·f[j].
  - Lane k is active only if base+k < OP_COUNT; inactive lanes read address 0 and their results are discarded.
  - Accumulators clear at group start. When the last product has been accumulated, the state goes to OUTPUT.
- **OUTPUT**
  - Lanes are presented in order k=0..L−1, one per handshake, where L = min(P, OP_COUNT−base).
  - After lane L−1 handshakes: base += P. If the new base < OP_COUNT the state goes to COMPUTE, otherwise to LOAD.
- Arithmetic:
  - Each product is the full 2T-bit result, saturated to [−2^(T−1), 2^(T−1)−1].
  - The accumulator is T+1 bits; after every add, the value is saturated to the signed T range before the next add.
  - The final value passes through the output stage (see Configuration).
- Filter memory and x memory are not cleared by reset; coefficients persist across vectors until rewritten.

## Timing
- Reset values: s_ready_x=1, s_ready_f=1, m_valid_y=0, m_data_out_y=0. State=LOAD; wp_x=wp_f=base=lane index=0; accumulators=0.
- Reset asserted in any state aborts the operation immediately. Partially loaded x and partial results are discarded.
- Memory read latency is 1 cycle and the multiply is registered, so a COMPUTE group lasts exactly F_COUNT+3 cycles.
- m_valid_y rises on the first cycle of OUTPUT.
- Vector latency from the last x handshake to the first m_valid_y is F_COUNT+4 cycles.
- While m_valid_y=1 and m_ready_y=0, m_data_out_y and the lane index are held. m_valid_y never drops without a handshake.
- m_data_out_y is 0 whenever m_valid_y=0.
- With m_ready_y held at 1, one result per cycle is delivered within a group, and there are F_COUNT+3 gap cycles between groups.
- s_valid_x/s_valid_f asserted outside LOAD are ignored; no write occurs.
- The input throughput limit is one sample and one coefficient per cycle.

## Configuration
- CONV_RELU_EN
  - Defined: the output stage maps negative final values to 0 (ReLU), and positives pass through saturated.
  - Undefined: the final value is emitted as a signed saturated T-bit result.
- Accumulation-time saturation is identical in both builds.

## Test plan
- Defaults, f[j]=1 and x[i]=1 for all i → 32 results, each 33; the first m_valid_y arrives 37 cycles after the last x handshake.
- X_COUNT=9, F_COUNT=3, P=4, x=0..8, f=(1,1,1) → 7 results 3,6,9,12,15,18,21 (groups of 4 then 3), then s_ready_x=1.
- x=32767, f=32767 (defaults) → every product saturates to 32767 and every result is 32767; with x=1, f=−1, results are −33, or 0 with CONV_RELU_EN.
- m_ready_y held low 5 cycles during lane 2 of a group → m_data_out_y is unchanged for those 5 cycles; the sequence of values delivered is unchanged and none is lost.
- reset pulsed mid-COMPUTE → outputs return to reset values asynchronously; reloading x only (filter retained) gives correct results.
- Coefficients streamed during the same LOAD window as x, with 40 coefficients sent → wp_f wraps, so f[0..6] holds coefficients 33..39; the results match a reference model computed with those values.
